// File: rtl/lc3_memory_responder_if.sv
// LC-3 processor memory bus: word address, write strobe and the two data directions.
// The processor drives the request side; the memory responder returns read data.
interface lc3_memory_responder_if;
    logic        writeEnable;
    logic [15:0] address;
    logic [15:0] dataToMemory;
    logic [15:0] dataFromMemory;

    modport master (
        output writeEnable,
        output address,
        output dataToMemory,
        input  dataFromMemory
    );

    modport slave (
        input  writeEnable,
        input  address,
        input  dataToMemory,
        output dataFromMemory
    );
endinterface

// File: rtl/lc3_memory_responder.sv
// LC-3 memory responder: word RAM with preload port plus keyboard/display MMIO registers.
// Reads are combinational so the processor can sample data on the edge after it drives address.
module lc3_memory_responder #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [15:0] KBSR_ADDR  = 16'hFE00,
    parameter logic [15:0] KBDR_ADDR  = 16'hFE02,
    parameter logic [15:0] DSR_ADDR   = 16'hFE04,
    parameter logic [15:0] DDR_ADDR   = 16'hFE06
) (
    input  logic                  clk,
    input  logic                  reset,
    lc3_memory_responder_if.slave bus,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [15:0]           load_data,
    input  logic                  kb_valid,
    input  logic [7:0]            kb_data,
    output logic                  kb_ready,
    output logic                  disp_valid,
    output logic [7:0]            disp_data,
    input  logic                  disp_ready,
    output logic [15:0]           disp_drop_count
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        DISP_IDLE = 1'b0,
        DISP_BUSY = 1'b1
    } disp_state_t;

    logic [15:0] ram [0:DEPTH-1];

    disp_state_t disp_state_reg, disp_state_next;
    logic [7:0]  ddr_reg, ddr_next;
    logic [15:0] drop_count_reg, drop_count_next;
    logic        kb_full_reg, kb_full_next;
    logic        kb_ie_reg, kb_ie_next;
    logic [7:0]  kbdr_reg, kbdr_next;

    logic                  hit_kbsr, hit_kbdr, hit_dsr, hit_ddr, hit_mmio;
    logic [ADDR_WIDTH-1:0] cpu_index;
    logic                  ram_we;
    logic                  kbdr_read;
    logic                  ddr_write;
    logic                  dsr_ready;

    // ------------------------------------------------------------------
    // Address decode: exact MMIO match wins, everything else aliases into RAM
    // ------------------------------------------------------------------
    assign hit_kbsr  = (bus.address == KBSR_ADDR);
    assign hit_kbdr  = (bus.address == KBDR_ADDR);
    assign hit_dsr   = (bus.address == DSR_ADDR);
    assign hit_ddr   = (bus.address == DDR_ADDR);
    assign hit_mmio  = hit_kbsr | hit_kbdr | hit_dsr | hit_ddr;
    assign cpu_index = bus.address[ADDR_WIDTH-1:0];
    assign ram_we    = bus.writeEnable & ~hit_mmio;
    assign kbdr_read = hit_kbdr & ~bus.writeEnable;
    assign ddr_write = hit_ddr & bus.writeEnable;
    assign dsr_ready = (disp_state_reg == DISP_IDLE);

    // ------------------------------------------------------------------
    // RAM: CPU port then preload port, so preload wins on an index collision
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[cpu_index] <= bus.dataToMemory;
        end
        if (load_en) begin
            ram[load_addr] <= load_data;
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        bus.dataFromMemory = ram[cpu_index];
        if (hit_kbsr) begin
            bus.dataFromMemory = {kb_full_reg, kb_ie_reg, 14'h0000};
        end else if (hit_kbdr) begin
            bus.dataFromMemory = {8'h00, kbdr_reg};
        end else if (hit_dsr) begin
            bus.dataFromMemory = {dsr_ready, 15'h0000};
        end else if (hit_ddr) begin
            bus.dataFromMemory = {8'h00, ddr_reg};
        end
    end

    // ------------------------------------------------------------------
    // Keyboard channel: EMPTY/FULL flag in KBSR[15]
    // ------------------------------------------------------------------
    // Holding off the keyboard while KBDR is addressed keeps a new character
    // from being cleared by the same read that consumes the old one.
    assign kb_ready = ~kb_full_reg & ~kbdr_read;

    always_comb begin
        kb_full_next = kb_full_reg;
        kb_ie_next   = kb_ie_reg;
        kbdr_next    = kbdr_reg;
        if (kb_valid && kb_ready) begin
            kb_full_next = 1'b1;
            kbdr_next    = kb_data;
        end else if (kbdr_read) begin
            kb_full_next = 1'b0;
        end
        if (hit_kbsr && bus.writeEnable) begin
            kb_ie_next = bus.dataToMemory[14];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kb_full_reg <= 1'b0;
            kb_ie_reg   <= 1'b0;
            kbdr_reg    <= 8'h00;
        end else begin
            kb_full_reg <= kb_full_next;
            kb_ie_reg   <= kb_ie_next;
            kbdr_reg    <= kbdr_next;
        end
    end

    // ------------------------------------------------------------------
    // Display channel FSM: IDLE (DSR ready) / BUSY (character pending)
    // ------------------------------------------------------------------
    always_comb begin
        disp_state_next = disp_state_reg;
        ddr_next        = ddr_reg;
        drop_count_next = drop_count_reg;
        case (disp_state_reg)
            DISP_IDLE: begin
                if (ddr_write) begin
                    ddr_next        = bus.dataToMemory[7:0];
                    disp_state_next = DISP_BUSY;
                end
            end
            DISP_BUSY: begin
                if (disp_ready) begin
                    disp_state_next = DISP_IDLE;
                end
                // DSR is still 0 on this edge, so any DDR write here is lost.
                if (ddr_write && (drop_count_reg != 16'hFFFF)) begin
                    drop_count_next = drop_count_reg + 16'd1;
                end
            end
            default: begin
                disp_state_next = DISP_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp_state_reg <= DISP_IDLE;
            ddr_reg        <= 8'h00;
            drop_count_reg <= 16'h0000;
        end else begin
            disp_state_reg <= disp_state_next;
            ddr_reg        <= ddr_next;
            drop_count_reg <= drop_count_next;
        end
    end

    assign disp_valid      = (disp_state_reg == DISP_BUSY);
    assign disp_data       = ddr_reg;
    assign disp_drop_count = drop_count_reg;

endmodule

// File: doc/lc3_memory_responder.md
Name: lc3_memory_responder

Overview:
- Memory-side responder for the LC-3 processor bus (clk, writeEnable, address, dataToMemory, dataFromMemory). It answers every processor read and write.
- Contents: a word-addressed RAM, plus the standard LC-3 memory-mapped keyboard and display registers.
- The keyboard and display registers bridge to external keyboard and display handshakes.
- A preload port lets the bench or boot logic load a program image before the processor runs.

Parameters:
- ADDR_WIDTH, 10, number of RAM index bits; RAM depth is 2**ADDR_WIDTH words of 16 bits.
- KBSR_ADDR, 16'hFE00, keyboard status register address.
- KBDR_ADDR, 16'hFE02, keyboard data register address.
- DSR_ADDR, 16'hFE04, display status register address.
- DDR_ADDR, 16'hFE06, display data register address.

Ports:
- clk  input  1  the single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- writeEnable  input  1  processor write strobe; one write per cycle it is high.
- address  input  16  processor word address.
- dataToMemory  input  16  processor write data.
- dataFromMemory  output  16  read data returned to the processor.
- load_en  input  1  preload write strobe.
- load_addr  input  ADDR_WIDTH  preload RAM index.
- load_data  input  16  preload data.
- kb_valid  input  1  keyboard character offered.
- kb_data  input  8  keyboard character.
- kb_ready  output  1  responder accepts the keyboard character this cycle.
- disp_valid  output  1  display character pending.
- disp_data  output  8  display character.
- disp_ready  input  1  display consumes the character this cycle.
- disp_drop_count  output  16  count of DDR writes discarded while the display was busy.

Behaviour:
- Reset (reset=0, asynchronous):
  - KBSR=0, KBDR=0, DSR=16'h8000, DDR=0.
  - disp_valid=0, disp_drop_count=0.
  - RAM contents are untouched by reset.
- Address decode:
  - MMIO match is an exact 16-bit compare against the four MMIO addresses, and takes priority over RAM.
  - Every other address hits RAM index address[ADDR_WIDTH-1:0]; upper bits alias (wrap-around).
- Read path:
  - dataFromMemory is combinational from address: RAM word, KBSR, KBDR, DSR or DDR.
  - Latency is zero cycles, because the processor samples data on the edge after it drives address.
  - Reads of RAM locations never written since power-up are X; this is not checked.
- RAM write: at a rising edge with writeEnable=1 and a non-MMIO address, ram[index] <= dataToMemory.
- Preload write:
  - At a rising edge with load_en=1, ram[load_addr] <= load_data.
  - Same edge and same index as a CPU write: the preload wins.
  - Different indices: both writes occur.
- KBSR:
  - Bit 15 = character ready; bit 14 = interrupt enable.
  - A CPU write to KBSR_ADDR updates bit 14 only. Other bits read as 0.
- Keyboard handshake:
  - kb_ready = ~KBSR[15] & ~(address==KBDR_ADDR & ~writeEnable).
  - On kb_valid & kb_ready: KBDR <= {8'h00, kb_data}, KBSR[15] <= 1.
- KBDR read side effect:
  - Each edge with address==KBDR_ADDR and writeEnable=0 clears KBSR[15]. KBDR itself holds its value.
  - Blocking kb_ready while KBDR is addressed prevents a new character being cleared unseen.
  - CPU writes to KBDR_ADDR are ignored.
- Display registers:
  - DSR bit 15 = display ready; CPU writes to DSR_ADDR are ignored.
  - DDR holds {8'h00, disp_data}.
- Display write:
  - CPU write to DDR_ADDR with DSR[15]=1: DDR[7:0] <= dataToMemory[7:0], DSR[15] <= 0, disp_valid <= 1 (visible next cycle).
  - CPU write to DDR_ADDR with DSR[15]=0: data discarded; disp_drop_count increments and saturates at 16'hFFFF.
- Display handshake:
  - On disp_valid & disp_ready: disp_valid <= 0, DSR[15] <= 1.
  - A DDR write on that same edge sees DSR[15]=0 and is dropped (counted).
  - disp_data is stable while disp_valid=1.
- State machine (display channel):
  - IDLE (DSR[15]=1, disp_valid=0) -> BUSY on an accepted DDR write.
  - BUSY (DSR[15]=0, disp_valid=1) -> IDLE on disp_ready.
  - The keyboard channel is a two-state EMPTY/FULL flag in KBSR[15].
- Reset mid-operation: any pending display character and keyboard character are lost; both channels return to the reset values above.

Test Plan:
- Preload: load 16'h1234 at index 5, set address=16'h0005 -> dataFromMemory=16'h1234 the same cycle; address=16'h0405 (alias) -> 16'h1234.
- CPU write vs preload: one-cycle writeEnable with address=16'h0010, dataToMemory=16'hBEEF -> readback 16'hBEEF. Same edge preload index 16 with 16'h0001 -> readback 16'h0001.
- Keyboard: kb_valid with kb_data=8'h41 -> kb_ready=1, next cycle KBSR=16'h8000, KBDR=16'h0041, kb_ready=0. Read KBDR_ADDR for one edge, then move address -> KBSR=16'h0000, kb_ready=1.
- Display: write 16'h0048 to DDR_ADDR -> disp_valid=1, disp_data=8'h48, DSR=16'h0000. Second write 16'h0049 while busy -> disp_drop_count=1, disp_data stays 8'h48. disp_ready pulse -> disp_valid=0, DSR=16'h8000.
- Reset mid-operation: assert reset=0 asynchronously (between edges) while disp_valid=1 and KBSR[15]=1 -> immediately disp_valid=0, DSR=16'h8000, KBSR=0, disp_drop_count=0; a RAM word written before reset is still readable afterwards.
